// File: rtl/limn2600_cache_pkg.sv
// Shared types and address helpers for the Limn2600 data cache controller.
package limn2600_cache_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_WRITE,
        ST_RESP
    } cache_state_t;

    // Tag width left over once the byte offset and index are removed.
    function automatic int unsigned tag_w(input int unsigned idx_w);
        return ADDR_W - 2 - idx_w;
    endfunction

    // Word index of a byte address, zero-extended to 32 bits.
    function automatic logic [31:0] idx_of(input logic [31:0] addr, input int unsigned idx_w);
        return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag of a byte address, zero-extended to 32 bits.
    function automatic logic [31:0] tag_of(input logic [31:0] addr, input int unsigned idx_w);
        return addr >> (2 + idx_w);
    endfunction

endpackage

// File: rtl/limn2600_cache_tagram.sv
// Data + tag storage with a separate valid vector. Writes are synchronous,
// reads are combinational. Only the valid bits carry meaning after reset;
// they are cleared one entry per cycle through the clear port.
module limn2600_cache_tagram #(
    parameter int unsigned NUM_ENTRIES = 4096,
    parameter int unsigned IDX_W       = 12,
    parameter int unsigned TAG_W       = 18,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_en,
    input  logic [IDX_W-1:0]      clr_idx
);

    logic [DATA_WIDTH-1:0] data_mem [NUM_ENTRIES];
    logic [TAG_W-1:0]      tag_mem  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid;

    // Array write: data and tag land together on an allocate.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx] <= wr_data;
            tag_mem[wr_idx]  <= wr_tag;
        end
    end

    // Valid bits: clear has priority (never concurrent with a write in practice).
    always_ff @(posedge clk) begin
        if (clr_en)
            valid[clr_idx] <= 1'b0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    // Asynchronous read port.
    always_comb begin
        rd_valid = valid[rd_idx];
        rd_tag   = tag_mem[rd_idx];
        rd_data  = data_mem[rd_idx];
    end

endmodule

// File: rtl/limn2600_cache_ctrl.sv
// Limn2600 data cache controller: hits served locally, one-word refill on a
// load miss, write-through with write-allocate on stores, walking flush.
module limn2600_cache_ctrl
    import limn2600_cache_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4096,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned TAG_W = tag_w(IDX_W);

    cache_state_t state, state_nxt;

    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_we;
    logic [IDX_W-1:0]      cnt;
    logic                  flush_pend;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hit;
    logic                  ack;
    logic                  wr_en;
    logic                  clr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    assign idx = IDX_W'(idx_of(req_addr, IDX_W));
    assign tag = TAG_W'(tag_of(req_addr, IDX_W));
    assign hit = rd_valid && (rd_tag == tag);
    assign ack = bus_ack && bus_req;

    limn2600_cache_tagram #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W),
        .TAG_W       (TAG_W),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_tagram (
        .clk      (clk),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (wr_data),
        .clr_en   (clr_en),
        .clr_idx  (cnt)
    );

    // State register; reset lands in FLUSH so the valid walk runs first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_FLUSH;
        else
            state <= state_nxt;
    end

    // Next-state, array strobes and handshake outputs.
    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        clr_en     = 1'b0;
        wr_data    = (state == ST_FILL) ? bus_rdata : req_wdata;
        cpu_ready  = (state == ST_IDLE) && !flush;
        cpu_rvalid = (state == ST_RESP);
        case (state)
            ST_FLUSH: begin
                clr_en = 1'b1;
                if (cnt == IDX_W'(NUM_ENTRIES - 1))
                    state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (flush)
                    state_nxt = ST_FLUSH;
                else if (cpu_req)
                    state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (req_we)
                    state_nxt = ST_WRITE;
                else if (hit)
                    state_nxt = ST_RESP;
                else
                    state_nxt = ST_FILL;
            end
            ST_FILL, ST_WRITE: begin
                if (ack) begin
                    wr_en     = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = (flush_pend || flush) ? ST_FLUSH : ST_IDLE;
            end
            default: state_nxt = ST_FLUSH;
        endcase
    end

    // Request latch, flush counter/latch, response data and registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            req_we     <= 1'b0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            cpu_rdata  <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            if (cpu_req && cpu_ready) begin
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
                req_we    <= cpu_we;
            end

            if (state == ST_FLUSH)
                cnt <= cnt + IDX_W'(1);

            // A flush arriving mid-request is deferred until the response is out.
            if (state == ST_RESP)
                flush_pend <= 1'b0;
            else if (flush && (state != ST_IDLE) && (state != ST_FLUSH))
                flush_pend <= 1'b1;

            case (state)
                ST_LOOKUP: begin
                    if (req_we) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_wdata <= req_wdata;
                    end else if (hit) begin
                        cpu_rdata <= rd_data;
                    end else begin
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= {req_addr[31:2], 2'b00};
                    end
                end
                ST_FILL, ST_WRITE: begin
                    if (ack) begin
                        bus_req   <= 1'b0;
                        cpu_rdata <= (state == ST_FILL) ? bus_rdata : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_limn2600_cache_ctrl.sv
// Directed + randomized bench for limn2600_cache_ctrl (NUM_ENTRIES=16).
// Reference: a per-index map of the cached word address plus a memory map.
module tb_limn2600_cache_ctrl;

    localparam int unsigned NE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] line_of [int];      // index -> word address currently cached
    logic [31:0] mem     [logic [31:0]];

    limn2600_cache_ctrl #(.NUM_ENTRIES(NE), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_mem(input logic [31:0] a);
        if (!mem.exists(a))
            mem[a] = $urandom;
        return mem[a];
    endfunction

    // Counts low cpu_ready samples (one per cycle) starting at the current negedge.
    task automatic wait_ready(output int n);
        n = 0;
        while (!cpu_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // One CPU transaction with a bus responder; ack_dly cycles after bus_req rises.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_dly, input int flush_cyc, input string tag);
        logic [31:0] waddr;
        logic [31:0] exp_rdata;
        logic [31:0] b_addr, b_wdata, rv_data;
        logic        b_we;
        int          idx, n, bus_first, rv_cnt, rv_cyc;
        bit          exp_hit, bus_seen, stable, acked, late;

        waddr     = addr & 32'hFFFF_FFFC;
        idx       = int'((waddr >> 2) % NE);
        exp_hit   = !we && line_of.exists(idx) && (line_of[idx] == waddr);
        exp_rdata = we ? 32'h0 : get_mem(waddr);
        bus_seen = 0; stable = 1; acked = 0; late = 0;
        bus_first = 0; rv_cnt = 0; rv_cyc = 0; rv_data = '0;
        b_addr = '0; b_wdata = '0; b_we = 1'b0;

        n = 0;
        while (!cpu_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_ready"}, {31'b0, cpu_ready}, 32'd1);

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;

        for (int c = 1; c <= 60 && rv_cnt == 0; c++) begin
            bus_ack = 1'b0;
            flush   = (c == flush_cyc);
            if (bus_req) begin
                if (acked) late = 1;
                if (!bus_seen) begin
                    bus_seen = 1; bus_first = c;
                    b_addr = bus_addr; b_we = bus_we; b_wdata = bus_wdata;
                end else if (bus_addr !== b_addr || bus_we !== b_we || bus_wdata !== b_wdata) begin
                    stable = 0;
                end
                if (!acked && c == bus_first + ack_dly) begin
                    bus_ack = 1'b1;
                    bus_rdata = get_mem(bus_addr);
                    acked = 1;
                end
            end
            if (cpu_rvalid) begin
                rv_cnt++; rv_cyc = c; rv_data = cpu_rdata;
            end
            if (rv_cnt == 0) @(negedge clk);
        end
        bus_ack = 1'b0;
        flush   = 1'b0;
        @(negedge clk);

        check({tag, "_rvalid_once"}, {31'b0, cpu_rvalid}, 32'd0);
        check({tag, "_rv_cnt"}, rv_cnt, 32'd1);
        check({tag, "_rdata"}, rv_data, exp_rdata);
        check({tag, "_bus_used"}, {31'b0, bus_seen}, {31'b0, !exp_hit});
        check({tag, "_bus_idle"}, {31'b0, bus_req}, 32'd0);
        if (bus_seen) begin
            check({tag, "_bus_addr"}, b_addr, waddr);
            check({tag, "_bus_we"}, {31'b0, b_we}, {31'b0, we});
            if (we) check({tag, "_bus_wdata"}, b_wdata, wdata);
            check({tag, "_bus_stable"}, {31'b0, stable}, 32'd1);
            check({tag, "_bus_drop"}, {31'b0, late}, 32'd0);
            check({tag, "_miss_lat"}, rv_cyc, bus_first + ack_dly + 1);
        end
        if (exp_hit) check({tag, "_hit_lat"}, rv_cyc, 32'd2);

        // Write-through and allocate on both fills and stores.
        if (we) mem[waddr] = wdata;
        line_of[idx] = waddr;
        if (flush_cyc > 0) line_of.delete();
    endtask

    initial begin
        int n;
        int waited;
        logic [31:0] a;

        rst = 1'b0; flush = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;

        // Reset values and post-reset flush walk.
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'b0, cpu_ready},  32'd0);
        check("rst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        check("rst_rdata",  cpu_rdata, 32'd0);
        check("rst_busreq", {31'b0, bus_req}, 32'd0);
        check("rst_buswe",  {31'b0, bus_we},  32'd0);
        check("rst_busaddr", bus_addr, 32'd0);
        check("rst_buswdata", bus_wdata, 32'd0);
        rst = 1'b1;
        wait_ready(n);
        check("rst_walk_cycles", n, NE);

        // Cold miss, then hit.
        mem[32'h100] = 32'hDEADBEEF;
        do_req(1'b0, 32'h100, 32'h0, 2, 0, "cold_ld100");
        do_req(1'b0, 32'h100, 32'h0, 0, 0, "hit_ld100");

        // Store write-through, then hit on the stored word.
        do_req(1'b1, 32'h104, 32'h12345678, 1, 0, "st104");
        do_req(1'b0, 32'h104, 32'h0, 0, 0, "ld104");

        // Same index, different tag: mutual eviction.
        do_req(1'b0, 32'h140, 32'h0, 0, 0, "alias_ld140");
        do_req(1'b0, 32'h100, 32'h0, 3, 0, "alias_ld100");

        // Flush during a delayed fill: fill completes, then a full walk.
        do_req(1'b0, 32'h180, 32'h0, 5, 3, "flush_fill");
        wait_ready(n);
        check("flush_walk_cycles", n, NE);
        do_req(1'b0, 32'h180, 32'h0, 0, 0, "after_flush");

        // Randomized traffic over a few tags per index.
        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
              | (32'($urandom_range(0, 1)) << 31) | 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 0, "rand");
        end

        // Reset in the middle of a bus cycle.
        waited = 0;
        while (!cpu_ready && waited < 40) begin waited++; @(negedge clk); end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1C0; cpu_wdata = 32'hCAFEF00D;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
        waited = 0;
        while (!bus_req && waited < 10) begin waited++; @(negedge clk); end
        check("midbus_req_seen", {31'b0, bus_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("midbus_busreq_drop", {31'b0, bus_req}, 32'd0);
        check("midbus_rvalid_low",  {31'b0, cpu_rvalid}, 32'd0);
        check("midbus_ready_low",   {31'b0, cpu_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_ready(n);
        check("midbus_walk_cycles", n, NE);
        line_of.delete();
        do_req(1'b0, 32'h1C0, 32'h0, 1, 0, "post_rst_ld");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
